// File: rtl/rpn_pkg.sv
// Shared RPN datapath constants: default stack geometry and pop_cnt encodings
// used by the stack, the operator decoder and the op controller.
package rpn_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    POP_NONE    = 2'd0,
    POP_UNARY   = 2'd1,
    POP_BINARY  = 2'd2,
    POP_TERNARY = 2'd3
  } pop_cnt_e;

endpackage

// File: rtl/rpn_stack_mem.sv
// Operand stack storage: one synchronous write port plus asynchronous reads at
// sp-1, sp-2, sp-3 (operands) and a peek port for the post-pop top of stack.
module rpn_stack_mem
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [DW-1:0]    sp,
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic [WIDTH-1:0] peek_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Slots below the bottom of the stack read as zero so unused operands are clean.
  always_comb begin
    rd1       = (sp >= DW'(1)) ? mem[AW'(sp - DW'(1))] : '0;
    rd2       = (sp >= DW'(2)) ? mem[AW'(sp - DW'(2))] : '0;
    rd3       = (sp >= DW'(3)) ? mem[AW'(sp - DW'(3))] : '0;
    peek_data = mem[peek_idx];
  end

endmodule

// File: rtl/rpn_stack.sv
// RPN operand stack: push port for parsed numbers/results, 1-3 operand pops to the ALU.
// Optional synchronous clear input enabled by defining RPN_STACK_CLEAR_EN.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int DW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [1:0]       pop_cnt,
`ifdef RPN_STACK_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] opc,
  output logic             op_valid,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             underflow,
  output logic             overflow
);

  logic [DW-1:0]    sp;
  logic [DW-1:0]    n_req, popped, sp_after_pop, sp_next;
  logic             pop_req, pop_ok, pop_bad, push_ok, mem_we, hold_off;
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] rd1, rd2, rd3, peek_data;
  logic [WIDTH-1:0] opa_nxt, opb_nxt, opc_nxt, top_nxt;

`ifdef RPN_STACK_CLEAR_EN
  assign hold_off = rst | clear;
`else
  assign hold_off = rst;
`endif

  // Pop is resolved first, then the push sees the room the pop freed up.
  always_comb begin
    n_req        = DW'(pop_cnt);
    pop_req      = (pop_cnt != POP_NONE);
    pop_ok       = pop_req && (n_req <= sp);
    pop_bad      = pop_req && !pop_ok;
    popped       = pop_ok ? n_req : '0;
    sp_after_pop = sp - popped;
    push_ok      = push && (sp_after_pop < DW'(DEPTH));
    sp_next      = sp_after_pop + (push_ok ? DW'(1) : DW'(0));
    mem_we       = push_ok && !hold_off;
    peek_idx     = (sp_after_pop != '0) ? AW'(sp_after_pop - DW'(1)) : '0;
    if (push_ok)                top_nxt = push_data;
    else if (sp_after_pop != '0) top_nxt = peek_data;
    else                        top_nxt = '0;
  end

  always_comb begin
    opa_nxt = '0;
    opb_nxt = '0;
    opc_nxt = '0;
    if (pop_ok) begin
      case (pop_cnt)
        POP_UNARY: opc_nxt = rd1;
        POP_BINARY: begin
          opb_nxt = rd2;
          opc_nxt = rd1;
        end
        POP_TERNARY: begin
          opa_nxt = rd3;
          opb_nxt = rd2;
          opc_nxt = rd1;
        end
        default: ;
      endcase
    end
  end

  rpn_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .DW   (DW),
    .AW   (AW)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (AW'(sp_after_pop)),
    .wdata    (push_data),
    .sp       (sp),
    .peek_idx (peek_idx),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd3      (rd3),
    .peek_data(peek_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      opa       <= '0;
      opb       <= '0;
      opc       <= '0;
      op_valid  <= 1'b0;
      top       <= '0;
      depth     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end
`ifdef RPN_STACK_CLEAR_EN
    else if (clear) begin
      sp        <= '0;
      opa       <= '0;
      opb       <= '0;
      opc       <= '0;
      op_valid  <= 1'b0;
      top       <= '0;
      depth     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end
`endif
    else begin
      sp        <= sp_next;
      opa       <= opa_nxt;
      opb       <= opb_nxt;
      opc       <= opc_nxt;
      op_valid  <= pop_ok;
      top       <= top_nxt;
      depth     <= sp_next;
      empty     <= (sp_next == '0);
      full      <= (sp_next == DW'(DEPTH));
      underflow <= underflow | pop_bad;
      overflow  <= overflow | (push && !push_ok);
    end
  end

endmodule

// File: tb/tb_rpn_stack.sv
// Directed self-checking bench for rpn_stack (WIDTH=16, DEPTH=8); the clear
// scenario is compiled in only when RPN_STACK_CLEAR_EN is defined.
module tb_rpn_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [15:0] push_data;
  logic [1:0]  pop_cnt;
`ifdef RPN_STACK_CLEAR_EN
  logic        clear;
`endif
  logic [15:0] opa, opb, opc, top;
  logic        op_valid, empty, full, underflow, overflow;
  logic [3:0]  depth;

  int checks   = 0;
  int failures = 0;

  rpn_stack #(.WIDTH(16), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop_cnt  (pop_cnt),
`ifdef RPN_STACK_CLEAR_EN
    .clear    (clear),
`endif
    .opa      (opa),
    .opb      (opb),
    .opc      (opc),
    .op_valid (op_valid),
    .top      (top),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .underflow(underflow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; push_data = '0; pop_cnt = 2'd0; rst = 1'b0;
`ifdef RPN_STACK_CLEAR_EN
    clear = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic do_push(input logic [15:0] v);
    idle();
    push = 1'b1; push_data = v;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (depth !== 4'd0) begin failures++; $display("[TB] FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("[TB] FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    checks++; if (op_valid !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b%b%b exp=000", op_valid, underflow, overflow); end
    checks++; if ({opa, opb, opc, top} !== 64'd0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", {opa, opb, opc, top}); end
  endtask

  task automatic test_pop2();
    do_reset();
    do_push(16'd5);
    do_push(16'd7);
    checks++; if (top !== 16'd7 || depth !== 4'd2) begin failures++; $display("[TB] FAIL pop2_prepush got top=%0d depth=%0d exp top=7 depth=2", top, depth); end
    pop_cnt = 2'd2;
    cycle();
    idle();
    checks++; if (opa !== 16'd0 || opb !== 16'd5 || opc !== 16'd7) begin failures++; $display("[TB] FAIL pop2_operands got=%0d,%0d,%0d exp=0,5,7", opa, opb, opc); end
    checks++; if (op_valid !== 1'b1) begin failures++; $display("[TB] FAIL pop2_valid got=%b exp=1", op_valid); end
    checks++; if (depth !== 4'd0 || empty !== 1'b1 || top !== 16'd0) begin failures++; $display("[TB] FAIL pop2_state got depth=%0d empty=%b top=%0d exp 0,1,0", depth, empty, top); end
    cycle();
    checks++; if (op_valid !== 1'b0) begin failures++; $display("[TB] FAIL pop2_valid_drop got=%b exp=0", op_valid); end
  endtask

  task automatic test_rpn_sequence();
    do_reset();
    do_push(16'd3);
    do_push(16'd4);
    pop_cnt = 2'd2;
    cycle();
    idle();
    checks++; if (opb !== 16'd3 || opc !== 16'd4 || op_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_operands got=%0d,%0d v=%b exp=3,4 v=1", opb, opc, op_valid); end
    do_push(16'd12);
    checks++; if (top !== 16'd12 || depth !== 4'd1) begin failures++; $display("[TB] FAIL seq_result got top=%0d depth=%0d exp 12,1", top, depth); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_push(16'd9);
    pop_cnt = 2'd2;
    cycle();
    idle();
    checks++; if (op_valid !== 1'b0 || underflow !== 1'b1) begin failures++; $display("[TB] FAIL uflow_flags got v=%b uf=%b exp v=0 uf=1", op_valid, underflow); end
    checks++; if (depth !== 4'd1 || top !== 16'd9 || {opa, opb, opc} !== 48'd0) begin failures++; $display("[TB] FAIL uflow_state got depth=%0d top=%0d ops=%h exp 1,9,0", depth, top, {opa, opb, opc}); end
    do_push(16'd1);
    checks++; if (depth !== 4'd2 || top !== 16'd1 || underflow !== 1'b1) begin failures++; $display("[TB] FAIL uflow_recover got depth=%0d top=%0d uf=%b exp 2,1,1", depth, top, underflow); end
  endtask

  task automatic test_overflow_replace();
    do_reset();
    for (int i = 1; i <= 8; i++) do_push(16'(i));
    checks++; if (full !== 1'b1 || depth !== 4'd8 || top !== 16'd8) begin failures++; $display("[TB] FAIL oflow_full got full=%b depth=%0d top=%0d exp 1,8,8", full, depth, top); end
    do_push(16'd99);
    checks++; if (overflow !== 1'b1 || top !== 16'd8 || depth !== 4'd8) begin failures++; $display("[TB] FAIL oflow_drop got of=%b top=%0d depth=%0d exp 1,8,8", overflow, top, depth); end
    push = 1'b1; push_data = 16'd42; pop_cnt = 2'd2;
    cycle();
    idle();
    checks++; if (opa !== 16'd0 || opb !== 16'd7 || opc !== 16'd8 || op_valid !== 1'b1) begin failures++; $display("[TB] FAIL replace_operands got=%0d,%0d,%0d v=%b exp=0,7,8 v=1", opa, opb, opc, op_valid); end
    checks++; if (top !== 16'd42 || depth !== 4'd7 || full !== 1'b0 || overflow !== 1'b1) begin failures++; $display("[TB] FAIL replace_state got top=%0d depth=%0d full=%b of=%b exp 42,7,0,1", top, depth, full, overflow); end
  endtask

  // Continues from the replace scenario: stack holds 1..6,42.
  task automatic test_back_to_back();
    pop_cnt = 2'd3;
    cycle();
    checks++; if (opa !== 16'd5 || opb !== 16'd6 || opc !== 16'd42 || op_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_pop3 got=%0d,%0d,%0d v=%b exp=5,6,42 v=1", opa, opb, opc, op_valid); end
    checks++; if (top !== 16'd4 || depth !== 4'd4) begin failures++; $display("[TB] FAIL b2b_pop3_state got top=%0d depth=%0d exp 4,4", top, depth); end
    pop_cnt = 2'd1;
    cycle();
    idle();
    checks++; if (opa !== 16'd0 || opb !== 16'd0 || opc !== 16'd4 || op_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_pop1 got=%0d,%0d,%0d v=%b exp=0,0,4 v=1", opa, opb, opc, op_valid); end
    checks++; if (top !== 16'd3 || depth !== 4'd3) begin failures++; $display("[TB] FAIL b2b_pop1_state got top=%0d depth=%0d exp 3,3", top, depth); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    do_push(16'd1);
    do_push(16'd2);
    pop_cnt = 2'd3;
    cycle();
    checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL mid_uflow_set got=%b exp=1", underflow); end
    rst = 1'b1; pop_cnt = 2'd1;
    cycle();
    idle();
    checks++; if (depth !== 4'd0 || op_valid !== 1'b0 || empty !== 1'b1 || top !== 16'd0) begin failures++; $display("[TB] FAIL mid_reset got depth=%0d v=%b empty=%b top=%0d exp 0,0,1,0", depth, op_valid, empty, top); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0 || full !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_flags got uf=%b of=%b full=%b exp 000", underflow, overflow, full); end
    do_push(16'd6);
    checks++; if (top !== 16'd6 || depth !== 4'd1) begin failures++; $display("[TB] FAIL mid_push got top=%0d depth=%0d exp 6,1", top, depth); end
  endtask

`ifdef RPN_STACK_CLEAR_EN
  task automatic test_clear();
    do_reset();
    pop_cnt = 2'd1;
    cycle();
    idle();
    checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL clr_uflow_set got=%b exp=1", underflow); end
    clear = 1'b1; push = 1'b1; push_data = 16'd5;
    cycle();
    idle();
    checks++; if (depth !== 4'd0 || underflow !== 1'b0 || top !== 16'd0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL clr_state got depth=%0d uf=%b top=%0d empty=%b exp 0,0,0,1", depth, underflow, top, empty); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_pop2();
    test_rpn_sequence();
    test_underflow();
    test_overflow_replace();
    test_back_to_back();
    test_reset_midstream();
`ifdef RPN_STACK_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpn_stack.md
# rpn_stack

Operand stack for the RPN calculator datapath: the responder to the operator controller's pop request (`pop_cnt` strobe) and the sink for parsed numbers and computed results. Numbers are pushed as they are parsed from UART input. When an operator fires, the block pops 1–3 operands and presents them, registered, to the ALU. The ALU's result is pushed back through the same push port.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits.
- `DEPTH`, 8: number of stack entries, ≥ 3, power of two not required.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push` in 1: one-cycle request to push `push_data`.
- `push_data` in WIDTH: value to push.
- `pop_cnt` in 2: operands to pop. 0 means no request. Nonzero means a request for one cycle.
- `opa` out WIDTH: deepest popped operand (left operand).
- `opb` out WIDTH: middle operand.
- `opc` out WIDTH: top-most popped operand.
- `op_valid` out 1: one-cycle strobe; operands valid.
- `top` out WIDTH: current top-of-stack, 0 when empty.
- `depth` out clog2(DEPTH+1): current entry count.
- `empty` out 1: `depth == 0`.
- `full` out 1: `depth == DEPTH`.
- `underflow` out 1: sticky error.
- `overflow` out 1: sticky error.
- `clear` in 1: present only with `RPN_STACK_CLEAR_EN`.

## Operation
- Storage: DEPTH×WIDTH register array. `sp` = `depth`. Entry `sp-1` is the top.
- Pop, n = `pop_cnt` ≠ 0, n ≤ `depth`:
  - Operands are right-aligned toward `opc`. Unused low-order slots read 0.
  - n=1: `opc`=top.
  - n=2: `opb`=top-1, `opc`=top.
  - n=3: `opa`=top-2, `opb`=top-1, `opc`=top.
  - `depth` -= n. `op_valid` pulses.
- Pop with n > `depth`:
  - Stack unchanged; `op_valid` stays 0; operands zero; `underflow` set.
  - A push in the same cycle still executes.
- Push, `depth` < DEPTH after pop accounting: write `push_data` at index (depth − popped), then `depth` += 1.
- Push with no room: data dropped, `depth` unchanged, `overflow` set.
- Simultaneous push and valid pop: pop is applied first, then the push.
  - New depth = depth − n + 1.
  - Operands are read from pre-update contents.
  - Example: full stack, pop 2 and push in the same cycle → legal, no overflow.
- Error flags stay set until `rst` (or `clear` when compiled in). Errors never block later operations.
- No state machine beyond `sp`. The block is a single-state responder; each cycle is fully resolved.

## Timing
- All outputs are registered. Reset values:
  - `opa`/`opb`/`opc`/`top`/`depth` = 0.
  - `op_valid` = 0, `empty` = 1, `full` = 0.
  - `underflow` = `overflow` = 0.
- Pop latency is 1. With `pop_cnt` sampled at edge k: operands and `op_valid` are valid after edge k, and `op_valid` drops after edge k+1 unless a new request arrives.
- `top`/`depth`/`empty`/`full` reflect the stack after the same edge that performed the operation.
- Back-to-back requests on consecutive cycles are each serviced; no stall, no ready signal.
- `pop_cnt` is level-sampled. A request held for m cycles pops m times. The caller guarantees single-cycle strobes.
- Reset mid-operation: `rst` wins over every other input that cycle. Stack contents need not be cleared, only `sp`.

## Configuration
- `RPN_STACK_CLEAR_EN` defined:
  - Adds the `clear` input.
  - `clear`=1 sets `depth` to 0 and clears `underflow`, `overflow`, `top` and `op_valid` in one cycle.
  - `clear` has priority over push/pop; lower priority than `rst`.
- Undefined: no `clear` port; only `rst` empties the stack.

## Structure
- Shared package `rpn_pkg` holds:
  - The default `WIDTH` and `DEPTH`.
  - Named constants for `pop_cnt` encodings (`POP_NONE`=0, `POP_UNARY`=1, `POP_BINARY`=2, `POP_TERNARY`=3), also used by the operator decoder and op controller.
- One sub-module, `rpn_stack_mem`:
  - Register array with one synchronous write port and three asynchronous read ports addressed at sp−1, sp−2, sp−3.
  - Pointer, error and output register logic stay in `rpn_stack`.

## Test plan
- Pop 2 after pushes: push 5, 7, then `pop_cnt`=2 → next cycle `opa`=0, `opb`=5, `opc`=7, `op_valid`=1 for one cycle; `depth`=0; `empty`=1.
- Full RPN sequence: push 3, 4, pop 2, push 12 → `top`=12, `depth`=1.
- Underflow: push 9, `pop_cnt`=2 → `op_valid` stays 0, `underflow`=1, `depth`=1, `top`=9. A subsequent push 1 succeeds with `depth`=2.
- Overflow then full-stack replace (DEPTH=8):
  - Push 1..8 → `full`=1.
  - Push 99 → `overflow`=1, `top`=8.
  - Same-cycle `pop_cnt`=2 plus push 42 → `opb`=7, `opc`=8, `top`=42, `depth`=7, `overflow` still 1 (sticky).
- Reset mid-stream: push 1, 2, then assert `rst` together with `pop_cnt`=1 → `depth`=0, `op_valid`=0, all flags 0. Next push 6 gives `top`=6.
- `RPN_STACK_CLEAR_EN` defined: underflow is set; `clear` pulse together with push 5 → `depth`=0, `underflow`=0, push ignored.
